inverse_freq_sched: RTL and testbench
=====================================

// Module: inverse_freq_sched
// PURPOSE
//  Run-level scheduler for the 2-source regularised-inverse engine. A single run_start
//  pulse walks the engine through every frequency bin: one start pulse per bin, wait for done.
//  Provides a per-bin timeout watchdog, a frequency index and a completion pulse.
//  Cross-checks the engine's all-frequency-finish flag. Sits between the host/control FSM and the inverse engine.
// PARAMETERS
//  FREQ_NUM        257   frequency bins per run
//  FREQ_CNT_WIDTH  9     width of freq_idx; must satisfy 2^FREQ_CNT_WIDTH >= FREQ_NUM
//  START_GAP       4     idle cycles between done edge and next inv_start; must be >= 1
//  TIMEOUT_CYC     4096  max cycles in WAIT_DONE before timeout; must be >= 2
//  TIMEOUT_WIDTH   13    timer width; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYC
// PORTS
//  clk                  in   1               single clock
//  rst_n                in   1               synchronous reset, active-low
//  run_start            in   1               pulse: begin a run at bin 0
//  run_abort            in   1               pulse: stop scheduling, return to IDLE
//  inv_start            out  1               1-cycle start pulse to inverse engine
//  inv_done             in   1               engine done level (stays high until engine restarts)
//  inv_all_freq_finish  in   1               engine 1-cycle last-bin flag
//  freq_idx             out  FREQ_CNT_WIDTH  bin currently scheduled
//  busy                 out  1               high in KICK/WAIT_DONE/GAP/FINISH
//  run_done             out  1               1-cycle pulse, run completed
//  err_timeout          out  1               sticky: WAIT_DONE exceeded TIMEOUT_CYC
//  err_sync             out  1               sticky: finish flag disagrees with freq_idx
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   state=IDLE; done_q=0; timer=0; all outputs 0 (inv_start, freq_idx, busy, run_done, err_*).
//  done_edge = inv_done & ~done_q. done_q is registered every cycle in every state.
//  All outputs are registered.
//  FSM:
//   IDLE -> KICK on run_start; freq_idx<=0; err_timeout<=0; err_sync<=0.
//   KICK: inv_start=1 for this cycle only; timer<=0; -> WAIT_DONE.
//   WAIT_DONE: timer++ each cycle.
//    - On done_edge:
//      - err_sync<=1 if inv_all_freq_finish != (freq_idx==FREQ_NUM-1), sampled in the edge cycle.
//      - -> FINISH if freq_idx==FREQ_NUM-1, else -> GAP with timer<=0.
//    - If no edge and timer==TIMEOUT_CYC-1: err_timeout<=1; -> ERROR.
//   GAP: timer++. When timer==START_GAP-1: freq_idx<=freq_idx+1; -> KICK.
//    - The gap lets the engine return to IDLE before the next kick.
//   FINISH: run_done=1 for one cycle; freq_idx holds FREQ_NUM-1; -> IDLE.
//   ERROR: busy=0; freq_idx holds failing bin; run_start ignored; -> IDLE on run_abort only.
//  Timing:
//   - run_start -> first inv_start: 1 cycle.
//   - done_edge -> next inv_start: START_GAP+1 cycles.
//   - Last done_edge -> run_done: 1 cycle.
//  Priority and boundary cases:
//   - run_abort beats everything, any state: -> IDLE next cycle. No run_done. err_* kept.
//     In-flight engine work is not cancelled.
//   - run_start while busy or in ERROR: ignored.
//   - run_start and run_abort together in IDLE: abort wins, stays IDLE.
//   - done_edge and timeout in the same cycle: done wins, no error.
//   - inv_done already high at KICK: no edge, so no advance until the engine drops and re-raises it.
//   - done_edge outside WAIT_DONE: ignored.
//   - freq_idx never wraps. FREQ_NUM=1 gives KICK -> WAIT_DONE -> FINISH.
//   - Reset mid-run: immediate IDLE on the next posedge, all outputs cleared.
// STRUCTURE
//  - Shared include inverse_pkg.vh: FREQ_NUM, FREQ_CNT_WIDTH, and state encodings
//    S_IDLE=0, S_KICK=1, S_WAIT_DONE=2, S_GAP=3, S_FINISH=4, S_ERROR=5 (3 bits).
//  - One sub-module inv_sched_timer: loadable up-counter with clear, enable and terminal
//    compare; shared by the timeout and gap phases.
//  - FSM, freq_idx and flags live in the top.
// TESTING
//  T1 FREQ_NUM=4, engine model raises done 20 cycles after each start and raises
//     all_freq_finish with the last done -> 4 inv_start pulses, freq_idx 0..3,
//     one run_done, err_*=0.
//  T2 Model never asserts done, TIMEOUT_CYC=16 -> err_timeout=1 exactly 16 cycles after
//     KICK, state ERROR, busy=0, freq_idx=0. run_start ignored; run_abort -> IDLE.
//  T3 all_freq_finish pulsed on bin 1 of 4 -> err_sync=1, run still completes with run_done.
//  T4 run_abort in WAIT_DONE of bin 2 -> IDLE next cycle, no run_done. A new run_start
//     restarts at freq_idx=0 with err_* cleared.
//  T5 Done edge on the same cycle timer reaches TIMEOUT_CYC-1 -> no error, advances to GAP.
//     Measure done_edge -> next inv_start = START_GAP+1 cycles.
//  T6 rst_n low for 1 cycle mid-GAP -> all outputs 0 next cycle.
//     Subsequent run_start behaves as in T1.

Source files
------------

// File: rtl/inverse_freq_sched_pkg.sv
// Shared defaults, FSM state encoding and small helpers for the run-level
// frequency-bin scheduler.
package inverse_freq_sched_pkg;

  localparam int FREQ_NUM_DEF       = 257;
  localparam int FREQ_CNT_WIDTH_DEF = 9;
  localparam int START_GAP_DEF      = 4;
  localparam int TIMEOUT_CYC_DEF    = 4096;
  localparam int TIMEOUT_WIDTH_DEF  = 13;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_KICK      = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_FINISH    = 3'd4,
    S_ERROR     = 3'd5
  } state_e;

  // ERROR is deliberately not busy so the host sees the run has stopped.
  function automatic logic is_busy(input state_e s);
    return (s == S_KICK) || (s == S_WAIT_DONE) || (s == S_GAP) || (s == S_FINISH);
  endfunction

endpackage

// File: rtl/inverse_freq_sched_if.sv
// Control/engine bundle between host FSM, scheduler and inverse engine.
// master = scheduler view, slave = host/engine view.
interface inverse_freq_sched_if
  import inverse_freq_sched_pkg::*;
#(
  parameter int FREQ_CNT_WIDTH = FREQ_CNT_WIDTH_DEF
);
  logic                      run_start;
  logic                      run_abort;
  logic                      inv_start;
  logic                      inv_done;
  logic                      inv_all_freq_finish;
  logic [FREQ_CNT_WIDTH-1:0] freq_idx;
  logic                      busy;
  logic                      run_done;
  logic                      err_timeout;
  logic                      err_sync;

  modport master (
    input  run_start, run_abort, inv_done, inv_all_freq_finish,
    output inv_start, freq_idx, busy, run_done, err_timeout, err_sync
  );

  modport slave (
    output run_start, run_abort, inv_done, inv_all_freq_finish,
    input  inv_start, freq_idx, busy, run_done, err_timeout, err_sync
  );
endinterface

// File: rtl/inv_sched_timer.sv
// Loadable up-counter with clear and enable; hit_o flags count == term_i.
// Shared between the done-timeout watchdog and the inter-kick gap.
module inv_sched_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             hit_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/inverse_freq_sched.sv
// Walks the inverse engine through every frequency bin per run: one kick per
// bin, waits for the done edge, with per-bin watchdog and finish-flag cross-check.
module inverse_freq_sched
  import inverse_freq_sched_pkg::*;
#(
  parameter int FREQ_NUM       = FREQ_NUM_DEF,
  parameter int FREQ_CNT_WIDTH = FREQ_CNT_WIDTH_DEF,
  parameter int START_GAP      = START_GAP_DEF,
  parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF,
  parameter int TIMEOUT_WIDTH  = TIMEOUT_WIDTH_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  inverse_freq_sched_if.master bus
);

  localparam logic [FREQ_CNT_WIDTH-1:0] LAST_IDX     = FREQ_CNT_WIDTH'(FREQ_NUM - 1);
  localparam logic [TIMEOUT_WIDTH-1:0]  TIMEOUT_TERM = TIMEOUT_WIDTH'(TIMEOUT_CYC - 1);
  localparam logic [TIMEOUT_WIDTH-1:0]  GAP_TERM     = TIMEOUT_WIDTH'(START_GAP - 1);

  state_e                    state_q, state_d;
  logic                      done_q;
  logic [FREQ_CNT_WIDTH-1:0] freq_idx_q, freq_idx_d;
  logic                      err_timeout_q, err_timeout_d;
  logic                      err_sync_q, err_sync_d;
  logic                      inv_start_q;
  logic                      busy_q;
  logic                      run_done_q;

  logic                      done_edge;
  logic                      last_bin;
  logic                      timer_clr;
  logic                      timer_en;
  logic                      timer_hit;
  logic [TIMEOUT_WIDTH-1:0]  timer_term;

  assign done_edge  = bus.inv_done & ~done_q;
  assign last_bin   = (freq_idx_q == LAST_IDX);
  assign timer_term = (state_q == S_GAP) ? GAP_TERM : TIMEOUT_TERM;

  inv_sched_timer #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (timer_clr),
    .en_i       (timer_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .term_i     (timer_term),
    .hit_o      (timer_hit)
  );

  always_comb begin
    state_d       = state_q;
    freq_idx_d    = freq_idx_q;
    err_timeout_d = err_timeout_q;
    err_sync_d    = err_sync_q;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run_start) begin
          state_d       = S_KICK;
          freq_idx_d    = '0;
          err_timeout_d = 1'b0;
          err_sync_d    = 1'b0;
        end
      end
      S_KICK: begin
        timer_clr = 1'b1;
        state_d   = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        timer_en = 1'b1;
        // A done edge on the watchdog's last cycle still counts as success.
        if (done_edge) begin
          if (bus.inv_all_freq_finish != last_bin) begin
            err_sync_d = 1'b1;
          end
          if (last_bin) begin
            state_d = S_FINISH;
          end else begin
            state_d   = S_GAP;
            timer_clr = 1'b1;
          end
        end else if (timer_hit) begin
          err_timeout_d = 1'b1;
          state_d       = S_ERROR;
        end
      end
      S_GAP: begin
        timer_en = 1'b1;
        if (timer_hit) begin
          freq_idx_d = freq_idx_q + FREQ_CNT_WIDTH'(1);
          state_d    = S_KICK;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides any transition and leaves index and sticky flags untouched.
    if (bus.run_abort) begin
      state_d       = S_IDLE;
      freq_idx_d    = freq_idx_q;
      err_timeout_d = err_timeout_q;
      err_sync_d    = err_sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      done_q        <= 1'b0;
      freq_idx_q    <= '0;
      err_timeout_q <= 1'b0;
      err_sync_q    <= 1'b0;
      inv_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_q        <= bus.inv_done;
      freq_idx_q    <= freq_idx_d;
      err_timeout_q <= err_timeout_d;
      err_sync_q    <= err_sync_d;
      inv_start_q   <= (state_d == S_KICK);
      busy_q        <= is_busy(state_d);
      run_done_q    <= (state_d == S_FINISH);
    end
  end

  assign bus.inv_start   = inv_start_q;
  assign bus.freq_idx    = freq_idx_q;
  assign bus.busy        = busy_q;
  assign bus.run_done    = run_done_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_sync    = err_sync_q;

endmodule

// File: tb/tb_inverse_freq_sched.sv
// Bench for inverse_freq_sched: engine model, freq_idx scoreboard on every
// inv_start, table of full runs plus hand sequences for timeout/abort/reset.
module tb_inverse_freq_sched;

  localparam int FN  = 4;
  localparam int GAP = 4;
  localparam int TO  = 16;
  localparam int CW  = 9;

  typedef struct {
    int delay;     // engine start -> done latency in cycles
    int fin_bin;   // bin on which the engine pulses all_freq_finish (-1: never)
    int exp_sync;  // expected err_sync after the run
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inverse_freq_sched_if #(.FREQ_CNT_WIDTH(CW)) bus ();

  inverse_freq_sched #(
    .FREQ_NUM       (FN),
    .FREQ_CNT_WIDTH (CW),
    .START_GAP      (GAP),
    .TIMEOUT_CYC    (TO),
    .TIMEOUT_WIDTH  (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int eng_delay   = 10;
  int eng_fin_bin = FN - 1;
  bit eng_never   = 1'b0;
  int eng_cnt     = 0;
  int eng_starts  = 0;

  int   cyc = 0;
  int   n_starts = 0;
  int   n_rd = 0;
  int   rs_cyc = 0;
  int   rd_cyc = 0;
  logic prev_done = 1'b0;
  int   exp_q[$];
  int   start_cyc[$];
  int   edge_cyc[$];

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.run_start = 1'b1;
    tick();
    bus.run_start = 1'b0;
  endtask

  task automatic clear_tracking();
    exp_q.delete();
    start_cyc.delete();
    edge_cyc.delete();
    n_starts   = 0;
    n_rd       = 0;
    eng_starts = 0;
  endtask

  // Engine: drops done when kicked, raises it eng_delay cycles later.
  initial begin
    bus.inv_done            = 1'b0;
    bus.inv_all_freq_finish = 1'b0;
    forever begin
      tick();
      bus.inv_all_freq_finish = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus.inv_done = 1'b1;
          if (eng_starts - 1 == eng_fin_bin) bus.inv_all_freq_finish = 1'b1;
        end
      end
      if (bus.inv_start === 1'b1) begin
        bus.inv_done = 1'b0;
        eng_starts++;
        eng_cnt = eng_never ? 0 : eng_delay;
      end
    end
  end

  // Monitor: scoreboard pop on every kick, event timestamps for latency checks.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.run_start === 1'b1) rs_cyc = cyc;
      if (bus.inv_done === 1'b1 && prev_done === 1'b0) edge_cyc.push_back(cyc);
      prev_done = bus.inv_done;
      if (bus.inv_start === 1'b1) begin
        n_starts++;
        start_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL start_unexpected: inv_start with freq_idx=%0d, none scheduled", bus.freq_idx);
        end else begin
          check("start_idx", int'(bus.freq_idx), exp_q.pop_front());
        end
      end
      if (bus.run_done === 1'b1) begin
        n_rd++;
        rd_cyc = cyc;
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    eng_delay   = v.delay;
    eng_fin_bin = v.fin_bin;
    eng_never   = 1'b0;
    clear_tracking();
    for (int i = 0; i < FN; i++) exp_q.push_back(i);
    pulse_start();
    for (int i = 0; i < 800 && n_rd == 0; i++) tick();
    if (n_rd == 0) begin
      total++;
      bad++;
      $display("FAIL %s_run_done_wait: no run_done within 800 cycles, starts=%0d", tag, n_starts);
    end
    tick();
    tick();
    check({tag, "_starts"},   n_starts, FN);
    check({tag, "_run_done"}, n_rd, 1);
    check({tag, "_err_to"},   int'(bus.err_timeout), 0);
    check({tag, "_err_sync"}, int'(bus.err_sync), v.exp_sync);
    check({tag, "_idx_end"},  int'(bus.freq_idx), FN - 1);
    check({tag, "_busy_end"}, int'(bus.busy), 0);
    check({tag, "_sb_left"},  exp_q.size(), 0);
    if (start_cyc.size() == FN && edge_cyc.size() == FN) begin
      check({tag, "_lat_first"}, start_cyc[0] - rs_cyc, 1);
      for (int i = 0; i < FN - 1; i++)
        check({tag, "_lat_gap"}, start_cyc[i+1] - edge_cyc[i], GAP + 1);
      check({tag, "_lat_done"}, rd_cyc - edge_cyc[FN-1], 1);
    end else begin
      total++;
      bad++;
      $display("FAIL %s_events: starts=%0d edges=%0d expected %0d each",
               tag, start_cyc.size(), edge_cyc.size(), FN);
    end
  endtask

  vec_t vecs[5];
  int   n;

  initial begin
    // Normal run, sync error on bin 1, done on the watchdog's last cycle,
    // minimum engine latency, finish flag never raised.
    vecs[0] = '{delay: 10, fin_bin: FN - 1, exp_sync: 0};
    vecs[1] = '{delay: 10, fin_bin: 1,      exp_sync: 1};
    vecs[2] = '{delay: TO, fin_bin: FN - 1, exp_sync: 0};
    vecs[3] = '{delay: 1,  fin_bin: FN - 1, exp_sync: 0};
    vecs[4] = '{delay: 15, fin_bin: -1,     exp_sync: 1};

    rst_n         = 1'b0;
    bus.run_start = 1'b0;
    bus.run_abort = 1'b0;
    repeat (2) tick();
    check("rst_inv_start", int'(bus.inv_start), 0);
    check("rst_freq_idx",  int'(bus.freq_idx), 0);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_run_done",  int'(bus.run_done), 0);
    check("rst_err_to",    int'(bus.err_timeout), 0);
    check("rst_err_sync",  int'(bus.err_sync), 0);
    rst_n = 1'b1;
    tick();

    // run_start together with run_abort in IDLE: abort wins.
    clear_tracking();
    bus.run_start = 1'b1;
    bus.run_abort = 1'b1;
    tick();
    bus.run_start = 1'b0;
    bus.run_abort = 1'b0;
    repeat (3) tick();
    check("startabort_busy",   int'(bus.busy), 0);
    check("startabort_starts", n_starts, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Watchdog: engine never finishes.
    clear_tracking();
    eng_never = 1'b1;
    exp_q.push_back(0);
    pulse_start();
    check("to_kick", int'(bus.inv_start), 1);
    n = 0;
    while (bus.err_timeout !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    // KICK cycle plus TO cycles in WAIT_DONE, flag visible the cycle after.
    check("to_latency", n, TO + 1);
    check("to_busy",    int'(bus.busy), 0);
    check("to_idx",     int'(bus.freq_idx), 0);
    pulse_start();
    repeat (3) tick();
    check("to_ignore_start", n_starts, 1);
    check("to_ignore_busy",  int'(bus.busy), 0);
    bus.run_abort = 1'b1;
    tick();
    bus.run_abort = 1'b0;
    check("to_abort_err_kept", int'(bus.err_timeout), 1);
    check("to_abort_busy",     int'(bus.busy), 0);
    run_vec(vecs[0], "after_to");

    // Abort in WAIT_DONE of bin 2.
    clear_tracking();
    eng_delay   = 10;
    eng_fin_bin = FN - 1;
    for (int i = 0; i < 3; i++) exp_q.push_back(i);
    pulse_start();
    for (int i = 0; i < 200 && n_starts < 3; i++) tick();
    repeat (4) tick();
    check("ab_busy_before", int'(bus.busy), 1);
    check("ab_idx_before",  int'(bus.freq_idx), 2);
    bus.run_abort = 1'b1;
    tick();
    bus.run_abort = 1'b0;
    check("ab_busy_after", int'(bus.busy), 0);
    repeat (30) tick();
    check("ab_no_run_done", n_rd, 0);
    check("ab_no_kick",     n_starts, 3);
    run_vec(vecs[0], "after_abort");

    // Reset pulse in the middle of GAP.
    clear_tracking();
    exp_q.push_back(0);
    pulse_start();
    for (int i = 0; i < 200 && edge_cyc.size() == 0; i++) tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_inv_start", int'(bus.inv_start), 0);
    check("mid_rst_freq_idx",  int'(bus.freq_idx), 0);
    check("mid_rst_busy",      int'(bus.busy), 0);
    check("mid_rst_run_done",  int'(bus.run_done), 0);
    check("mid_rst_err_to",    int'(bus.err_timeout), 0);
    check("mid_rst_err_sync",  int'(bus.err_sync), 0);
    repeat (10) tick();
    check("mid_rst_quiet", n_starts, 1);
    run_vec(vecs[0], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
